// File: rtl/fifo_pkg.sv
// Shared definitions for the flag-rich synchronous FIFO: address sizing,
// default thresholds and read-mode encodings.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_AF_MARGIN  = 2;
    localparam int DEF_AE_THRESH  = 2;

    function automatic int addr_w_f(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit is_pow2_f(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous
// read port, contents are never reset.
module fifo_mem_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with extra-bit pointers, occupancy count, programmable
// almost flags, sticky error flags and optional first-word-fall-through reads.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AF_THRESH  = FIFO_DEPTH - DEF_AF_MARGIN,
    parameter int AE_THRESH  = DEF_AE_THRESH,
    parameter int FWFT       = FIFO_MODE_STD
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cs,
    input  logic                          w_ena,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          r_ena,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [addr_w_f(FIFO_DEPTH):0] count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int ADDR_W = addr_w_f(FIFO_DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL  = (ADDR_W+1)'(AE_THRESH);

    generate
        if (!is_pow2_f(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo_flags: FIFO_DEPTH must be a power of two >= 2");
        end
        if (AF_THRESH > FIFO_DEPTH || AF_THRESH < 0) begin : g_bad_af
            $error("sync_fifo_flags: AF_THRESH out of range");
        end
        if (AE_THRESH >= FIFO_DEPTH || AE_THRESH < 0) begin : g_bad_ae
            $error("sync_fifo_flags: AE_THRESH out of range");
        end
        if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
            $error("sync_fifo_flags: FWFT must be 0 or 1");
        end
    endgenerate

    logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                full_w, empty_w;
    logic                wr_acc, rd_acc;
    logic                wr_req, rd_req;
    logic [DATA_WIDTH-1:0] rd_data;

    // Extra MSB distinguishes "same slot, one lap ahead" (full) from "same slot" (empty).
    assign empty_w = (rd_ptr_q == wr_ptr_q);
    assign full_w  = (rd_ptr_q[ADDR_W] != wr_ptr_q[ADDR_W]) &&
                     (rd_ptr_q[ADDR_W-1:0] == wr_ptr_q[ADDR_W-1:0]);

    assign wr_req = cs & w_ena;
    assign rd_req = cs & r_ena;
    assign wr_acc = wr_req & ~full_w;
    assign rd_acc = rd_req & ~empty_w;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase

        // Clear first so a coincident new error still latches.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_req && full_w) begin
            overflow_d = 1'b1;
        end
        if (rd_req && empty_w) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rd_data)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign data_out = empty_w ? '0 : rd_data;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_acc) begin
                    dout_d = rd_data;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
